// File: rtl/conv_acc_ctrl.sv
// Sequencer for the first-layer convolution accumulator: counts TAPS products per
// output pixel, hands each sum to the output stream and flags the end of a frame.
module conv_acc_ctrl #(
  parameter int TAPS    = 9,
  parameter int NUM_OUT = 676,
  parameter int RELU    = 0,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  input  logic        prod_valid,
  output logic        prod_ready,
  input  logic [31:0] prod_data,
  output logic        acc_en,
  output logic        acc_flush,
  output logic [31:0] acc_data,
  input  logic [31:0] acc_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NUM_OUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             done_q, done_d;
  logic             last_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tap_cnt_q <= '0;
      pix_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      done_q    <= done_d;
    end
  end

  assign last_pix = (pix_cnt_q == PIX_LAST);

  always_comb begin
    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    done_d     = 1'b0;
    prod_ready = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACCUM;
          tap_cnt_d = '0;
          pix_cnt_d = '0;
        end
      end
      S_ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          if (tap_cnt_q == TAP_LAST) begin
            tap_cnt_d = '0;
            state_d   = S_OUTPUT;
          end else begin
            tap_cnt_d = tap_cnt_q + CNT_W'(1);
          end
        end
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        out_last  = last_pix;
        if (out_ready) begin
          if (last_pix) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
            state_d   = S_ACCUM;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort beats every transition, including the one that would raise done
    if (abort) begin
      state_d   = S_IDLE;
      tap_cnt_d = '0;
      pix_cnt_d = '0;
      done_d    = 1'b0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign acc_flush = prod_ready & prod_valid & (tap_cnt_q == '0);
  assign acc_en    = prod_ready & prod_valid & (tap_cnt_q != '0);
  assign acc_data  = prod_data;
  assign out_data  = ((RELU != 0) && acc_result[31]) ? 32'd0 : acc_result;

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// Bench for conv_acc_ctrl: three configurations (TAPS/NUM_OUT/RELU = 3/2/0, 3/2/1, 1/3/0)
// driven one at a time against a frame-level model of pixel sums and an accumulator model.
module tb_conv_acc_ctrl;

  logic clk;
  logic rst_n;

  logic        start[3], abort[3], prod_valid[3], out_ready[3];
  logic [31:0] prod_data[3], acc_res[3];
  logic        busy_w[3], done_w[3], prod_ready_w[3], acc_en_w[3], acc_flush_w[3];
  logic        out_valid_w[3], out_last_w[3];
  logic [31:0] acc_data_w[3], out_data_w[3];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt[3];
  logic [31:0] exp_q[$];
  logic [31:0] src_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_acc_ctrl #(.TAPS(3), .NUM_OUT(2), .RELU(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .busy(busy_w[0]),
    .done(done_w[0]), .prod_valid(prod_valid[0]), .prod_ready(prod_ready_w[0]),
    .prod_data(prod_data[0]), .acc_en(acc_en_w[0]), .acc_flush(acc_flush_w[0]),
    .acc_data(acc_data_w[0]), .acc_result(acc_res[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]), .out_data(out_data_w[0]), .out_last(out_last_w[0]));

  conv_acc_ctrl #(.TAPS(3), .NUM_OUT(2), .RELU(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .busy(busy_w[1]),
    .done(done_w[1]), .prod_valid(prod_valid[1]), .prod_ready(prod_ready_w[1]),
    .prod_data(prod_data[1]), .acc_en(acc_en_w[1]), .acc_flush(acc_flush_w[1]),
    .acc_data(acc_data_w[1]), .acc_result(acc_res[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]), .out_data(out_data_w[1]), .out_last(out_last_w[1]));

  conv_acc_ctrl #(.TAPS(1), .NUM_OUT(3), .RELU(0), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .busy(busy_w[2]),
    .done(done_w[2]), .prod_valid(prod_valid[2]), .prod_ready(prod_ready_w[2]),
    .prod_data(prod_data[2]), .acc_en(acc_en_w[2]), .acc_flush(acc_flush_w[2]),
    .acc_data(acc_data_w[2]), .acc_result(acc_res[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready[2]), .out_data(out_data_w[2]), .out_last(out_last_w[2]));

  // accumulator model fed from the controller's en/flush/data_i, plus a done-pulse counter
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (acc_flush_w[i])   acc_res[i] <= acc_data_w[i];
      else if (acc_en_w[i]) acc_res[i] <= acc_res[i] + acc_data_w[i];
      if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  function automatic int taps_of(input int l);
    return (l == 2) ? 1 : 3;
  endfunction

  function automatic int nout_of(input int l);
    return (l == 2) ? 3 : 2;
  endfunction

  function automatic logic [31:0] relu_of(input int l, input logic [31:0] x);
    return (l == 1 && $signed(x) < 0) ? 32'd0 : x;
  endfunction

  function automatic logic [31:0] ctl(input int l);
    return {25'd0, busy_w[l], done_w[l], prod_ready_w[l], acc_en_w[l], acc_flush_w[l],
            out_valid_w[l], out_last_w[l]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle_inputs(input int l);
    start[l] = 1'b0; abort[l] = 1'b0; prod_valid[l] = 1'b0; out_ready[l] = 1'b0;
    prod_data[l] = 32'd0;
  endtask

  // Drives one full frame on lane l; entered and left on a negedge.
  task automatic run_frame(input int l, input int stall_pct, input int bp_pct,
                           input int hold, input bit noise);
    int taps, nout, k, pix, oh, edges, budget, c0;
    logic [31:0] sum, d;
    bit fin;
    taps = taps_of(l); nout = nout_of(l);
    k = 0; pix = 0; oh = 0; sum = 32'd0; fin = 1'b0; budget = 4000;
    c0 = done_cnt[l];
    exp_q.delete();
    start[l] = 1'b1;
    #1 check("idle_before_start", {31'd0, busy_w[l]}, 32'd0);
    @(posedge clk); edges = 1;
    @(negedge clk);
    while (!fin && budget > 0) begin
      budget--;
      prod_valid[l] = ($urandom_range(99) >= stall_pct);
      d = (src_q.size() > 0) ? src_q[0] : $urandom;
      prod_data[l] = d;
      out_ready[l] = (oh >= hold) && ($urandom_range(99) >= bp_pct);
      start[l] = noise && ($urandom_range(9) == 0);
      #1;
      check("busy_in_frame", {31'd0, busy_w[l]}, 32'd1);
      check("done_in_frame", {31'd0, done_w[l]}, 32'd0);
      if (k < taps) begin
        check("accum_ready", {31'd0, prod_ready_w[l]}, 32'd1);
        check("accum_valid", {31'd0, out_valid_w[l]}, 32'd0);
        check("acc_flush", {31'd0, acc_flush_w[l]}, {31'd0, prod_valid[l] && k == 0});
        check("acc_en", {31'd0, acc_en_w[l]}, {31'd0, prod_valid[l] && k != 0});
        if (prod_valid[l]) begin
          check("acc_data", acc_data_w[l], d);
          if (src_q.size() > 0) void'(src_q.pop_front());
          sum = (k == 0) ? d : sum + d;
          k++;
          if (k == taps) exp_q.push_back(relu_of(l, sum));
        end
      end else begin
        oh++;
        check("out_ready_low", {31'd0, prod_ready_w[l]}, 32'd0);
        check("out_acc_hold", {30'd0, acc_en_w[l], acc_flush_w[l]}, 32'd0);
        check("out_valid", {31'd0, out_valid_w[l]}, 32'd1);
        check("out_data", out_data_w[l], exp_q[0]);
        check("out_last", {31'd0, out_last_w[l]}, {31'd0, pix == nout - 1});
        if (out_ready[l]) begin
          void'(exp_q.pop_front());
          if (pix == nout - 1) fin = 1'b1;
          pix++; k = 0; oh = 0;
        end
      end
      @(posedge clk); edges++;
      @(negedge clk);
    end
    idle_inputs(l);
    if (!fin) check("frame_budget", 32'd0, 32'd1);
    #1;
    check("done_pulse", ctl(l), 32'h40 | 32'h20);
    if (stall_pct == 0 && bp_pct == 0 && hold == 0)
      check("frame_time", edges, nout * (taps + 1) + 1);
    @(posedge clk);
    @(negedge clk);
    #1 check("idle_after_done", ctl(l), 32'd0);
    check("done_count", done_cnt[l] - c0, 32'd1);
  endtask

  task automatic load_plan(input int l);
    if (l == 2) src_q = '{32'd7, 32'd8, 32'd9};
    else src_q = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'hFFFF_FFFA};
  endtask

  task automatic abort_test(input int l, input int n_taps);
    int c0;
    c0 = done_cnt[l];
    start[l] = 1'b1;
    @(posedge clk);
    @(negedge clk) start[l] = 1'b0;
    for (int i = 0; i < n_taps; i++) begin
      prod_valid[l] = 1'b1; prod_data[l] = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    prod_valid[l] = 1'b0; abort[l] = 1'b1;
    #1 check("busy_before_abort", {31'd0, busy_w[l]}, 32'd1);
    @(posedge clk);
    @(negedge clk) abort[l] = 1'b0;
    #1 check("after_abort", ctl(l), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt[l] - c0, 32'd0);
    start[l] = 1'b1; abort[l] = 1'b1;
    @(posedge clk);
    @(negedge clk) begin start[l] = 1'b0; abort[l] = 1'b0; end
    #1 check("start_abort_idle", ctl(l), 32'd0);
  endtask

  task automatic reset_test(input int l);
    start[l] = 1'b1;
    @(posedge clk);
    @(negedge clk) start[l] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      prod_valid[l] = 1'b1; prod_data[l] = 32'(i);
      @(posedge clk);
      @(negedge clk);
    end
    prod_valid[l] = 1'b0; out_ready[l] = 1'b0;
    #1 check("pre_reset_out", out_data_w[l], 32'd6);
    check("pre_reset_valid", {31'd0, out_valid_w[l]}, 32'd1);
    rst_n = 1'b0;
    #1 check("async_reset", ctl(l), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("no_self_restart", ctl(l), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      idle_inputs(i);
      done_cnt[i] = 0;
      acc_res[i]  = 32'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check("reset_outputs", ctl(i), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // lane 0: TAPS=3 NUM_OUT=2 RELU=0
    load_plan(0); run_frame(0, 0, 0, 0, 1'b0);
    load_plan(0); run_frame(0, 0, 0, 5, 1'b0);
    load_plan(0); run_frame(0, 50, 0, 0, 1'b0);
    load_plan(0); run_frame(0, 20, 20, 0, 1'b1);
    abort_test(0, 2);
    load_plan(0); run_frame(0, 0, 0, 0, 1'b0);
    reset_test(0);
    load_plan(0); run_frame(0, 0, 0, 0, 1'b0);
    for (int r = 0; r < 4; r++) run_frame(0, 30, 30, 1, 1'b1);

    // lane 1: ReLU on
    load_plan(1); run_frame(1, 0, 0, 0, 1'b0);
    for (int r = 0; r < 3; r++) run_frame(1, 30, 30, 0, 1'b1);

    // lane 2: single-tap pixels
    load_plan(2); run_frame(2, 0, 0, 0, 1'b0);
    abort_test(2, 1);
    for (int r = 0; r < 3; r++) run_frame(2, 30, 30, 2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_acc_ctrl.md
Name: conv_acc_ctrl

Overview:
- Sequencer for the first-layer convolution accumulator. It consumes a valid/ready stream of signed 32-bit products and drives the accumulator's en/flush/data_i.
- It counts TAPS products per output pixel and presents each finished sum on a valid/ready output stream, with optional ReLU.
- It counts NUM_OUT pixels per frame and pulses done at frame end.
- It sits between the multiplier array and the output buffer.

Parameters:
- TAPS, 9, products summed per output pixel (K*K*Cin); legal values 1..2^CNT_W-1.
- NUM_OUT, 676, output pixels per frame (26x26); legal values 1..2^CNT_W-1.
- RELU, 0, 1 = clamp negative results to 0 on out_data; 0 = pass the raw sum.
- CNT_W, 16, width of the tap and pixel counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle frame start; honoured only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- prod_valid  in  1  product stream valid.
- prod_ready  out  1  product stream ready.
- prod_data  in  32  signed product.
- acc_en  out  1  accumulator enable.
- acc_flush  out  1  accumulator flush (load data_i).
- acc_data  out  32  accumulator data_i; equals prod_data combinationally.
- acc_result  in  32  accumulator result_o.
- out_valid  out  1  result valid.
- out_ready  in  1  result ready.
- out_data  out  32  signed result: acc_result, or max(0, acc_result) when RELU=1.
- out_last  out  1  high with out_valid on the last pixel of the frame.

Behaviour:
- Reset: state IDLE; tap_cnt=0; pix_cnt=0. Outputs busy, done, prod_ready, acc_en, acc_flush, out_valid and out_last all 0.
- Only done is registered. All other outputs are decoded combinationally from state and counters.
- States are IDLE, ACCUM, OUTPUT and DONE.
- IDLE:
  - start=1 -> ACCUM, with tap_cnt=0 and pix_cnt=0.
  - start=0 -> remain in IDLE.
- ACCUM:
  - prod_ready=1.
  - accept = prod_valid & prod_ready.
  - acc_flush = accept & (tap_cnt==0).
  - acc_en = accept & (tap_cnt!=0).
  - acc_flush and acc_en are never high together.
  - On accept with tap_cnt==TAPS-1: tap_cnt=0, go to OUTPUT.
  - On accept with any other tap_cnt: tap_cnt++.
  - prod_valid=0 stalls the block with no change.
- OUTPUT:
  - prod_ready=0; acc_en=0 and acc_flush=0, so the accumulator holds.
  - out_valid=1; out_last = (pix_cnt==NUM_OUT-1).
  - out_data is stable while out_valid=1 and out_ready=0.
  - On out_ready with out_last=1: go to DONE.
  - On out_ready with out_last=0: pix_cnt++, go to ACCUM.
- DONE:
  - Lasts one cycle; done=1 in this cycle; then go to IDLE.
  - busy=1 in DONE.
- Latency:
  - out_valid rises in the cycle after the edge that accepts the last tap.
  - Minimum period per pixel is TAPS+1 cycles.
  - Minimum frame time is NUM_OUT*(TAPS+1)+1 cycles after start.
- TAPS=1: every accepted product is a flush and goes straight to OUTPUT; out_data equals that product.
- Arithmetic is 32-bit two's complement and wraps with no saturation; overflow is the accumulator's behaviour.
- ReLU: out_data = 0 when acc_result[31]=1.
- start while busy is ignored, with no effect on counters.
- abort has priority over all transitions in every state:
  - next state IDLE; counters cleared; no done pulse.
  - Outputs drop combinationally from the next cycle.
  - abort in IDLE has no effect; start and abort together in IDLE -> remain in IDLE.
- rst_n low mid-frame: immediate return to reset values. The next frame requires a new start.

Test Plan:
- TAPS=3, NUM_OUT=2, RELU=0:
  - start, then products 1,2,3 -> flush on 1, en on 2 and 3; out_valid with out_data=6, out_last=0.
  - Then -4,-5,-6 -> out_data=-15 with out_last=1.
  - done pulses once, 1 cycle after the second handshake; busy=0 the cycle after that.
- Same stimulus, RELU=1 -> outputs 6 then 0.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid stays 1, out_data=6 stable, prod_ready=0, acc_en=0.
- Input stalls: prod_valid toggled 1,0,0,1,0,1 -> exactly 3 accepts, result still 6, tap count unaffected by idle cycles.
- start pulsed during ACCUM -> ignored; pix_cnt unchanged.
- abort after 2 taps -> IDLE next cycle, no done pulse; a new frame with 1,2,3 yields 6.
- rst_n asserted during OUTPUT -> all outputs 0 asynchronously; restart yields the correct 6.
- TAPS=1, NUM_OUT=3, products 7,8,9 -> outputs 7,8,9; out_last on 9.
